bounds_table_om: RTL and testbench
==================================

BOUNDS_TABLE_OM -- requirements
Module: bounds_table_om

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, entry count; a power of two and at least 2.
REQ-003 SHALL have parameter N_PORTS, default 2, number of independent lookup ports.
REQ-004 SHALL have port clk_i  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clear_i  input  1  synchronous flush of the whole table.
REQ-007 SHALL have ports alloc_valid_i input 1 / alloc_ready_o output 1  allocation handshake.
REQ-008 SHALL have ports alloc_base_i / alloc_last_i  input  ADDR_W each  inclusive interval bounds; alloc_big_i  input  1  large-object flag.
REQ-009 SHALL have ports free_valid_i input 1 / free_base_i input ADDR_W  release request by base address.
REQ-010 SHALL have ports lookup_valid_i input N_PORTS / lookup_addr_i input N_PORTS x ADDR_W  query per port.
REQ-011 SHALL have outputs lookup_resp_valid_o, lookup_in_range_o, lookup_is_first_o, each N_PORTS wide  per-port results.
REQ-012 SHALL have outputs last_base_o / last_last_o, ADDR_W each  most recently written entry.
REQ-013 SHALL have output count_o, $clog2(DEPTH+1) wide  number of valid entries.
REQ-014 SHALL have 1-bit pulse outputs overwrite_o, alloc_err_o, free_miss_o and overlap_o.

Function
REQ-015 alloc_ready_o SHALL equal ~clear_i; an allocation is accepted when alloc_valid_i & alloc_ready_o.
REQ-016 An accepted allocation with alloc_last_i >= alloc_base_i SHALL write {base, last, big, valid=1} at the cursor and advance the cursor modulo DEPTH (DEPTH-1 -> 0).
REQ-017 An accepted allocation with alloc_last_i < alloc_base_i SHALL write nothing, leave the cursor unchanged and pulse alloc_err_o for one cycle.
REQ-018 Writing over a valid slot SHALL pulse overwrite_o for one cycle; count_o then stays unchanged (saturates at DEPTH).
REQ-019 Free SHALL clear the valid bit of every valid entry whose base equals free_base_i, in one cycle, and decrement count_o by the number cleared; if none match, free_miss_o SHALL pulse.
REQ-020 For same-cycle alloc and free, free SHALL act on the pre-edge contents, the new entry SHALL be written valid regardless of a base match, and count_o SHALL reflect both.
REQ-021 Lookup SHALL have 1-cycle latency; lookup_resp_valid_o[p] is lookup_valid_i[p] delayed by one cycle.
REQ-022 lookup_in_range_o[p] SHALL be 1 iff some valid entry has base <= addr <= last (unsigned, inclusive).
REQ-023 lookup_is_first_o[p] SHALL be 1 iff some valid entry with big=0 has base == addr.
REQ-024 Result outputs SHALL be 0 whenever the matching resp_valid is 0; lookups SHALL see table state before a same-cycle write, free or clear.
REQ-025 last_base_o/last_last_o SHALL update only on a successful write and hold otherwise, including across frees.
REQ-026 clear_i SHALL invalidate all entries, zero the cursor, count_o and last_* registers, and take priority over same-cycle alloc and free.

Reset
REQ-027 On rst_ni low, all entries SHALL be invalid, cursor 0, and every output 0 except alloc_ready_o, which follows ~clear_i.
REQ-028 An alloc or free in flight when reset asserts SHALL be discarded; no pulse outputs SHALL survive reset.

Configuration
REQ-029 With BOUNDS_OVF_CHECK_EN defined, a successful write whose interval intersects any valid entry (excluding the overwritten slot) SHALL pulse overlap_o in the write cycle; the entry is still written.
REQ-030 Without BOUNDS_OVF_CHECK_EN, overlap_o SHALL be tied 0 and no overlap comparators SHALL be built.

Structure
REQ-031 Package bounds_pkg SHALL hold the default ADDR_W/DEPTH constants and a bounds_entry_t struct (base, last, big, valid).
REQ-032 A combinational sub-module bounds_match SHALL be instantiated once per lookup port, returning in_range and is_first over all entries.

Verification
REQ-033 Alloc [0x80001000,0x800010FF] big=0 -> count_o=1, last_base_o=0x80001000; lookups of 0x800010FF and 0x80001000 one cycle later -> in_range=1, is_first=1.
REQ-034 Lookup 0x80001100 on port 1 while port 0 queries 0x80001050 -> port 1 in_range=0, port 0 in_range=1, same cycle.
REQ-035 DEPTH+1 allocs of disjoint intervals -> overwrite_o pulses once on write DEPTH+1; count_o=DEPTH; first interval no longer hits.
REQ-036 Free 0x80001000 then free 0x80001000 again -> count_o decrements once; second free pulses free_miss_o.
REQ-037 Alloc base 0x200 last 0x1FF -> alloc_err_o pulse, count_o unchanged; clear_i with alloc_valid_i high -> alloc_ready_o=0, count_o=0 next cycle.
REQ-038 With BOUNDS_OVF_CHECK_EN: alloc [0x100,0x1FF] then [0x1F0,0x2FF] -> overlap_o pulses on second write; without the macro overlap_o stays 0.

Source files
------------

// File: rtl/bounds_pkg.sv
// bounds_pkg: default table geometry and the stored entry layout.
// Entry fields are DEFAULT_ADDR_W wide; a narrower ADDR_W is zero-extended into them.
package bounds_pkg;
    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DEPTH  = 64;

    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0] base;
        logic [DEFAULT_ADDR_W-1:0] last;
        logic                      big;
        logic                      valid;
    } bounds_entry_t;
endpackage

// File: rtl/bounds_match.sv
// bounds_match: combinational range / first-byte match of one address against every entry.
module bounds_match
    import bounds_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  bounds_entry_t [DEPTH-1:0]     entries,
    input  logic [DEFAULT_ADDR_W-1:0]     addr,
    output logic                          in_range,
    output logic                          is_first
);
    always_comb begin
        in_range = 1'b0;
        is_first = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_range = in_range | (entries[i].valid & (entries[i].base <= addr) & (addr <= entries[i].last));
            is_first = is_first | (entries[i].valid & ~entries[i].big & (entries[i].base == addr));
        end
    end
endmodule

// File: rtl/bounds_table_om.sv
// bounds_table_om: round-robin table of address intervals with multi-port registered lookup.
// Define BOUNDS_OVF_CHECK_EN to build the overlap detector driving overlap_o.
module bounds_table_om
    import bounds_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int N_PORTS = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clear_i,
    input  logic                             alloc_valid_i,
    output logic                             alloc_ready_o,
    input  logic [ADDR_W-1:0]                alloc_base_i,
    input  logic [ADDR_W-1:0]                alloc_last_i,
    input  logic                             alloc_big_i,
    input  logic                             free_valid_i,
    input  logic [ADDR_W-1:0]                free_base_i,
    input  logic [N_PORTS-1:0]               lookup_valid_i,
    input  logic [N_PORTS-1:0][ADDR_W-1:0]   lookup_addr_i,
    output logic [N_PORTS-1:0]               lookup_resp_valid_o,
    output logic [N_PORTS-1:0]               lookup_in_range_o,
    output logic [N_PORTS-1:0]               lookup_is_first_o,
    output logic [ADDR_W-1:0]                last_base_o,
    output logic [ADDR_W-1:0]                last_last_o,
    output logic [$clog2(DEPTH+1)-1:0]       count_o,
    output logic                             overwrite_o,
    output logic                             alloc_err_o,
    output logic                             free_miss_o,
    output logic                             overlap_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int BW    = DEFAULT_ADDR_W;

    bounds_entry_t [DEPTH-1:0] tbl_q, tbl_d;
    bounds_entry_t             new_e;
    logic [IDX_W-1:0]          cursor_q, cursor_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [ADDR_W-1:0]         last_base_q, last_base_d, last_last_q, last_last_d;
    logic [DEPTH-1:0]          free_match;
    logic                      alloc_go, wr_en;
    logic                      overwrite_q, overwrite_d, err_q, err_d, miss_q, miss_d;
    logic [N_PORTS-1:0]        hit_range, hit_first, resp_q, range_q, first_q;

    assign alloc_ready_o = ~clear_i;
    assign alloc_go      = alloc_valid_i & ~clear_i;
    assign wr_en         = alloc_go & (alloc_last_i >= alloc_base_i);
    assign new_e         = '{base: BW'(alloc_base_i), last: BW'(alloc_last_i), big: alloc_big_i, valid: 1'b1};

    // Free acts on pre-edge contents; the new write lands afterwards so it is valid even if its slot matched.
    always_comb begin
        tbl_d      = tbl_q;
        free_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            free_match[i] = free_valid_i & tbl_q[i].valid & (tbl_q[i].base == BW'(free_base_i));
            if (free_match[i]) tbl_d[i].valid = 1'b0;
        end
        if (wr_en) tbl_d[cursor_q] = new_e;
        if (clear_i) tbl_d = '0;
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) count_d = count_d + CNT_W'(tbl_d[i].valid);
    end

    assign cursor_d    = clear_i ? '0 : wr_en ? cursor_q + 1'b1 : cursor_q;
    assign last_base_d = clear_i ? '0 : wr_en ? alloc_base_i : last_base_q;
    assign last_last_d = clear_i ? '0 : wr_en ? alloc_last_i : last_last_q;
    assign overwrite_d = wr_en & tbl_q[cursor_q].valid & ~free_match[cursor_q];
    assign err_d       = alloc_go & (alloc_last_i < alloc_base_i);
    assign miss_d      = free_valid_i & ~clear_i & ~|free_match;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tbl_q       <= '0;
            cursor_q    <= '0;
            count_q     <= '0;
            last_base_q <= '0;
            last_last_q <= '0;
            overwrite_q <= 1'b0;
            err_q       <= 1'b0;
            miss_q      <= 1'b0;
        end else begin
            tbl_q       <= tbl_d;
            cursor_q    <= cursor_d;
            count_q     <= count_d;
            last_base_q <= last_base_d;
            last_last_q <= last_last_d;
            overwrite_q <= overwrite_d;
            err_q       <= err_d;
            miss_q      <= miss_d;
        end
    end

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        bounds_match #(.DEPTH(DEPTH)) u_match (
            .entries (tbl_q),
            .addr    (BW'(lookup_addr_i[p])),
            .in_range(hit_range[p]),
            .is_first(hit_first[p])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_q  <= '0;
            range_q <= '0;
            first_q <= '0;
        end else begin
            resp_q  <= lookup_valid_i;
            range_q <= lookup_valid_i & hit_range;
            first_q <= lookup_valid_i & hit_first;
        end
    end

`ifdef BOUNDS_OVF_CHECK_EN
    logic ovl_d, overlap_q;
    always_comb begin
        ovl_d = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            ovl_d = ovl_d | ((IDX_W'(i) != cursor_q) & tbl_q[i].valid &
                             (new_e.base <= tbl_q[i].last) & (tbl_q[i].base <= new_e.last));
        ovl_d = ovl_d & wr_en;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) overlap_q <= 1'b0;
        else         overlap_q <= ovl_d;
    end
    assign overlap_o = overlap_q;
`else
    assign overlap_o = 1'b0;
`endif

    assign lookup_resp_valid_o = resp_q;
    assign lookup_in_range_o   = range_q;
    assign lookup_is_first_o   = first_q;
    assign last_base_o         = last_base_q;
    assign last_last_o         = last_last_q;
    assign count_o             = count_q;
    assign overwrite_o         = overwrite_q;
    assign alloc_err_o         = err_q;
    assign free_miss_o         = miss_q;
endmodule

// File: tb/tb_bounds_table_om.sv
// tb_bounds_table_om: directed and randomized checks of bounds_table_om against an interval-list model.
module tb_bounds_table_om;
    localparam int ADDR_W  = 32;
    localparam int DEPTH   = 64;
    localparam int N_PORTS = 2;
    localparam int CNT_W   = $clog2(DEPTH+1);

    logic clk_i = 1'b0, rst_ni = 1'b0, clear_i = 1'b0;
    logic alloc_valid_i = 1'b0, alloc_big_i = 1'b0, free_valid_i = 1'b0;
    logic [ADDR_W-1:0] alloc_base_i = '0, alloc_last_i = '0, free_base_i = '0;
    logic [N_PORTS-1:0] lookup_valid_i = '0;
    logic [N_PORTS-1:0][ADDR_W-1:0] lookup_addr_i = '0;
    logic alloc_ready_o, overwrite_o, alloc_err_o, free_miss_o, overlap_o;
    logic [N_PORTS-1:0] lookup_resp_valid_o, lookup_in_range_o, lookup_is_first_o;
    logic [ADDR_W-1:0] last_base_o, last_last_o;
    logic [CNT_W-1:0] count_o;

    bounds_table_om #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .N_PORTS(N_PORTS)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
        .alloc_base_i(alloc_base_i), .alloc_last_i(alloc_last_i), .alloc_big_i(alloc_big_i),
        .free_valid_i(free_valid_i), .free_base_i(free_base_i),
        .lookup_valid_i(lookup_valid_i), .lookup_addr_i(lookup_addr_i),
        .lookup_resp_valid_o(lookup_resp_valid_o), .lookup_in_range_o(lookup_in_range_o),
        .lookup_is_first_o(lookup_is_first_o), .last_base_o(last_base_o), .last_last_o(last_last_o),
        .count_o(count_o), .overwrite_o(overwrite_o), .alloc_err_o(alloc_err_o),
        .free_miss_o(free_miss_o), .overlap_o(overlap_o)
    );

    always #5 clk_i = ~clk_i;

    logic [ADDR_W-1:0] mb[DEPTH], ml[DEPTH];
    bit mbig[DEPTH], mv[DEPTH];
    int mcur;
    logic [ADDR_W-1:0] m_lb, m_ll;
    logic [N_PORTS-1:0] e_rv, e_ir, e_if;
    logic e_ovw, e_err, e_miss, e_ovl;
    int n_checks = 0, n_fail = 0;

    wire [81:0] obs = {alloc_ready_o, lookup_resp_valid_o, lookup_in_range_o, lookup_is_first_o,
                       last_base_o, last_last_o, count_o, overwrite_o, alloc_err_o, free_miss_o, overlap_o};

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(mv[i]);
        return c;
    endfunction

    function automatic logic [81:0] exp_vec();
        return {~clear_i, e_rv, e_ir, e_if, m_lb, m_ll, CNT_W'(m_count()), e_ovw, e_err, e_miss, e_ovl};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
        mcur = 0; m_lb = '0; m_ll = '0;
        e_rv = '0; e_ir = '0; e_if = '0;
        e_ovw = 0; e_err = 0; e_miss = 0; e_ovl = 0;
    endtask

    task automatic set_idle();
        clear_i = 0; alloc_valid_i = 0; free_valid_i = 0; lookup_valid_i = '0; alloc_big_i = 0;
    endtask

    // Advance one clock, updating the model from the inputs currently applied.
    task automatic step();
        bit nv[DEPTH];
        bit hit;
        for (int p = 0; p < N_PORTS; p++) begin
            e_rv[p] = lookup_valid_i[p]; e_ir[p] = 0; e_if[p] = 0;
            if (lookup_valid_i[p])
                for (int i = 0; i < DEPTH; i++)
                    if (mv[i]) begin
                        if (mb[i] <= lookup_addr_i[p] && lookup_addr_i[p] <= ml[i]) e_ir[p] = 1;
                        if (!mbig[i] && mb[i] == lookup_addr_i[p]) e_if[p] = 1;
                    end
        end
        e_ovw = 0; e_err = 0; e_miss = 0; e_ovl = 0;
        if (clear_i) begin
            for (int i = 0; i < DEPTH; i++) mv[i] = 0;
            mcur = 0; m_lb = '0; m_ll = '0;
        end else begin
            nv = mv; hit = 0;
            if (free_valid_i)
                for (int i = 0; i < DEPTH; i++)
                    if (mv[i] && mb[i] == free_base_i) begin nv[i] = 0; hit = 1; end
            e_miss = free_valid_i && !hit;
            if (alloc_valid_i && alloc_last_i < alloc_base_i) e_err = 1;
            else if (alloc_valid_i) begin
`ifdef BOUNDS_OVF_CHECK_EN
                for (int i = 0; i < DEPTH; i++)
                    if (i != mcur && mv[i] && alloc_base_i <= ml[i] && mb[i] <= alloc_last_i) e_ovl = 1;
`endif
                e_ovw = nv[mcur];
                nv[mcur] = 1; mb[mcur] = alloc_base_i; ml[mcur] = alloc_last_i; mbig[mcur] = alloc_big_i;
                mcur = (mcur + 1) % DEPTH;
                m_lb = alloc_base_i; m_ll = alloc_last_i;
            end
            mv = nv;
        end
        @(posedge clk_i); #1;
    endtask

    task automatic do_alloc(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l, input logic big);
        alloc_valid_i = 1; alloc_base_i = b; alloc_last_i = l; alloc_big_i = big;
        step();
        alloc_valid_i = 0; alloc_big_i = 0;
    endtask

    task automatic do_clear();
        set_idle(); clear_i = 1; step(); clear_i = 0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (obs !== {1'b1, 81'b0}) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", obs, {1'b1, 81'b0}); end
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1;
        model_reset();
    endtask

    task automatic test_alloc_lookup();
        do_alloc(32'h8000_1000, 32'h8000_10FF, 0);
        n_checks++;
        if (count_o !== CNT_W'(1)) begin n_fail++; $display("FAIL alloc_count: got %0d want 1", count_o); end
        n_checks++;
        if (last_base_o !== 32'h8000_1000) begin n_fail++; $display("FAIL alloc_last_base: got %h want 80001000", last_base_o); end
        lookup_valid_i = 2'b11; lookup_addr_i[0] = 32'h8000_10FF; lookup_addr_i[1] = 32'h8000_1000;
        n_checks++;
        if (lookup_resp_valid_o !== 2'b00) begin n_fail++; $display("FAIL lookup_latency: got %b want 00", lookup_resp_valid_o); end
        step();
        n_checks++;
        if ({lookup_resp_valid_o, lookup_in_range_o, lookup_is_first_o} !== 6'b11_11_10) begin
            n_fail++; $display("FAIL lookup_hit: got %b want 111110", {lookup_resp_valid_o, lookup_in_range_o, lookup_is_first_o});
        end
        lookup_addr_i[0] = 32'h8000_1050; lookup_addr_i[1] = 32'h8000_1100;
        step();
        n_checks++;
        if (lookup_in_range_o !== 2'b01) begin n_fail++; $display("FAIL lookup_ports: got %b want 01", lookup_in_range_o); end
        lookup_valid_i = '0;
        step();
        n_checks++;
        if ({lookup_resp_valid_o, lookup_in_range_o, lookup_is_first_o} !== 6'b0) begin
            n_fail++; $display("FAIL lookup_idle_zero: got %b want 000000", {lookup_resp_valid_o, lookup_in_range_o, lookup_is_first_o});
        end
    endtask

    task automatic test_wrap();
        int ovw_cnt = 0, ovw_at = -1;
        do_clear();
        for (int i = 0; i <= DEPTH; i++) begin
            do_alloc(32'h4000_0000 + 32'(i) * 32'h100, 32'h4000_00FF + 32'(i) * 32'h100, 0);
            if (overwrite_o) begin ovw_cnt++; ovw_at = i + 1; end
        end
        n_checks++;
        if (ovw_cnt != 1 || ovw_at != DEPTH + 1) begin n_fail++; $display("FAIL wrap_overwrite: got %0d pulses at write %0d want 1 at %0d", ovw_cnt, ovw_at, DEPTH + 1); end
        n_checks++;
        if (count_o !== CNT_W'(DEPTH)) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", count_o, DEPTH); end
        lookup_valid_i = 2'b11; lookup_addr_i[0] = 32'h4000_0000; lookup_addr_i[1] = 32'h4000_0100;
        step();
        lookup_valid_i = '0;
        n_checks++;
        if (lookup_in_range_o !== 2'b10) begin n_fail++; $display("FAIL wrap_evicted: got %b want 10", lookup_in_range_o); end
    endtask

    task automatic test_free();
        do_clear();
        do_alloc(32'h8000_1000, 32'h8000_10FF, 0);
        free_valid_i = 1; free_base_i = 32'h8000_1000;
        step();
        n_checks++;
        if (count_o !== CNT_W'(0) || free_miss_o !== 1'b0) begin n_fail++; $display("FAIL free_hit: got count %0d miss %b want 0 0", count_o, free_miss_o); end
        step();
        free_valid_i = 0;
        n_checks++;
        if (count_o !== CNT_W'(0) || free_miss_o !== 1'b1) begin n_fail++; $display("FAIL free_again: got count %0d miss %b want 0 1", count_o, free_miss_o); end
        n_checks++;
        if (last_base_o !== 32'h8000_1000) begin n_fail++; $display("FAIL free_keeps_last: got %h want 80001000", last_base_o); end
    endtask

    task automatic test_err_clear();
        do_alloc(32'h100, 32'h1FF, 0);
        do_alloc(32'h200, 32'h1FF, 0);
        n_checks++;
        if (alloc_err_o !== 1'b1 || count_o !== CNT_W'(1)) begin n_fail++; $display("FAIL alloc_err: got err %b count %0d want 1 1", alloc_err_o, count_o); end
        n_checks++;
        if (last_base_o !== 32'h100) begin n_fail++; $display("FAIL err_no_write: got %h want 100", last_base_o); end
        step();
        n_checks++;
        if (alloc_err_o !== 1'b0) begin n_fail++; $display("FAIL err_pulse_width: got %b want 0", alloc_err_o); end
        clear_i = 1; alloc_valid_i = 1; alloc_base_i = 32'h300; alloc_last_i = 32'h3FF;
        #1;
        n_checks++;
        if (alloc_ready_o !== 1'b0) begin n_fail++; $display("FAIL clear_ready: got %b want 0", alloc_ready_o); end
        step();
        set_idle();
        n_checks++;
        if (count_o !== CNT_W'(0) || last_base_o !== '0 || alloc_err_o !== 1'b0) begin
            n_fail++; $display("FAIL clear_flush: got count %0d last %h err %b want 0 0 0", count_o, last_base_o, alloc_err_o);
        end
    endtask

    task automatic test_overlap();
        logic want;
`ifdef BOUNDS_OVF_CHECK_EN
        want = 1'b1;
`else
        want = 1'b0;
`endif
        do_clear();
        do_alloc(32'h100, 32'h1FF, 0);
        n_checks++;
        if (overlap_o !== 1'b0) begin n_fail++; $display("FAIL overlap_first: got %b want 0", overlap_o); end
        do_alloc(32'h1F0, 32'h2FF, 0);
        n_checks++;
        if (overlap_o !== want || count_o !== CNT_W'(2)) begin n_fail++; $display("FAIL overlap_second: got %b count %0d want %b 2", overlap_o, count_o, want); end
    endtask

    task automatic test_back_to_back();
        do_clear();
        do_alloc(32'h500, 32'h5FF, 1);
        free_valid_i = 1; free_base_i = 32'h500;
        alloc_valid_i = 1; alloc_base_i = 32'h500; alloc_last_i = 32'h57F; alloc_big_i = 0;
        step();
        set_idle();
        n_checks++;
        if (count_o !== CNT_W'(1) || free_miss_o !== 1'b0 || overwrite_o !== 1'b0) begin
            n_fail++; $display("FAIL same_cycle_alloc_free: got count %0d miss %b ovw %b want 1 0 0", count_o, free_miss_o, overwrite_o);
        end
        lookup_valid_i = 2'b11; lookup_addr_i[0] = 32'h500; lookup_addr_i[1] = 32'h5C0;
        step();
        lookup_valid_i = '0;
        n_checks++;
        if ({lookup_in_range_o, lookup_is_first_o} !== 4'b01_01) begin
            n_fail++; $display("FAIL same_cycle_lookup: got %b want 0101", {lookup_in_range_o, lookup_is_first_o});
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            clear_i = ($urandom_range(0, 39) == 0);
            alloc_valid_i = $urandom_range(0, 1) == 1;
            alloc_base_i = 32'h100 * 32'($urandom_range(0, 7));
            alloc_last_i = ($urandom_range(0, 15) == 0) ? alloc_base_i - 1 : alloc_base_i + 32'($urandom_range(0, 'h17F));
            alloc_big_i = $urandom_range(0, 3) == 0;
            free_valid_i = $urandom_range(0, 2) == 0;
            free_base_i = 32'h100 * 32'($urandom_range(0, 7));
            lookup_valid_i = N_PORTS'($urandom_range(0, 3));
            for (int p = 0; p < N_PORTS; p++) lookup_addr_i[p] = 32'($urandom_range(0, 'h900));
            step();
            n_checks++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL random_cycle_%0d: got %h want %h", c, obs, exp_vec()); end
        end
        set_idle();
    endtask

    task automatic test_reset_inflight();
        do_alloc(32'h700, 32'h7FF, 0);
        alloc_valid_i = 1; alloc_base_i = 32'h800; alloc_last_i = 32'h8FF;
        free_valid_i = 1; free_base_i = 32'h999;
        #2 rst_ni = 0;
        #1;
        n_checks++;
        if (obs !== {1'b1, 81'b0}) begin n_fail++; $display("FAIL async_reset: got %h want %h", obs, {1'b1, 81'b0}); end
        @(posedge clk_i); #1;
        set_idle();
        #2 rst_ni = 1;
        @(posedge clk_i); #1;
        model_reset();
        step();
        n_checks++;
        if (obs !== exp_vec() || count_o !== CNT_W'(0)) begin n_fail++; $display("FAIL reset_discard: got %h want %h", obs, exp_vec()); end
    endtask

    initial begin
        test_reset();
        test_alloc_lookup();
        test_wrap();
        test_free();
        test_err_clear();
        test_overlap();
        test_back_to_back();
        test_random();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
